// File: rtl/icache_rxdat_merge.sv
// Purpose : gathers out-of-order, entry-interleaved downstream beats into per-MSHR-entry line
//           buffers. Each completed line is issued once on txdat, and the entry is then freed
//           with a dealloc pulse.
// Latency : completing beat accepted at T -> txdat_vld at T+2 (output free); handshake at T ->
//           dealloc_vld at T+1.
// Backpr. : rxdat is never stalled (rxdat_rdy = !rst). txdat holds its line while txdat_rdy=0,
//           and finished lines wait in their own entry buffers.
//
// Ports:
//   clk, rst                                    clock, async active-high reset
//   alloc_vld/alloc_entry_id/alloc_txnid         MSHR allocates an entry and its upstream txnid
//   rxdat_vld/rdy/entry_id/beat_idx/data         downstream beat channel
//   txdat_vld/rdy/data/txnid/entry_id            upstream assembled-line channel
//   dealloc_vld/dealloc_entry_id                 one-cycle entry-free pulse
//   err_stray                                    sticky: stray/duplicate beat or alloc to a busy entry
module icache_rxdat_merge #(
    parameter int LINE_WIDTH  = 256,
    parameter int BEAT_WIDTH  = 64,
    parameter int ENTRY_NUM   = 8,
    parameter int TXNID_WIDTH = 8,
    localparam int BEATS       = LINE_WIDTH / BEAT_WIDTH,
    localparam int ENTRY_IDX_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1,
    localparam int BEAT_IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_vld,
    input  logic [ENTRY_IDX_W-1:0] alloc_entry_id,
    input  logic [TXNID_WIDTH-1:0] alloc_txnid,
    input  logic                   rxdat_vld,
    output logic                   rxdat_rdy,
    input  logic [ENTRY_IDX_W-1:0] rxdat_entry_id,
    input  logic [BEAT_IDX_W-1:0]  rxdat_beat_idx,
    input  logic [BEAT_WIDTH-1:0]  rxdat_data,
    output logic                   txdat_vld,
    input  logic                   txdat_rdy,
    output logic [LINE_WIDTH-1:0]  txdat_data,
    output logic [TXNID_WIDTH-1:0] txdat_txnid,
    output logic [ENTRY_IDX_W-1:0] txdat_entry_id,
    output logic                   dealloc_vld,
    output logic [ENTRY_IDX_W-1:0] dealloc_entry_id,
    output logic                   err_stray
);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE, ST_OUT} ent_state_t;

    ent_state_t             state_q [ENTRY_NUM];
    ent_state_t             state_d [ENTRY_NUM];
    logic [BEATS-1:0]       mask_q  [ENTRY_NUM];
    logic [BEATS-1:0]       mask_d  [ENTRY_NUM];
    logic [LINE_WIDTH-1:0]  line_q  [ENTRY_NUM];
    logic [TXNID_WIDTH-1:0] txnid_q [ENTRY_NUM];
    logic [ENTRY_IDX_W-1:0] rr_q;

    logic                   alloc_ok;
    logic                   beat_wr;
    logic                   stray;
    logic                   sel_vld;
    logic [ENTRY_IDX_W-1:0] sel;
    logic                   load;
    logic                   hs;

    assign rxdat_rdy = !rst;
    assign hs        = txdat_vld && txdat_rdy;

    always_comb begin
        alloc_ok = 1'b0;
        beat_wr  = 1'b0;
        stray    = 1'b0;
        sel_vld  = 1'b0;
        sel      = '0;
        for (int e = 0; e < ENTRY_NUM; e++) begin
            state_d[e] = state_q[e];
            mask_d[e]  = mask_q[e];
        end

        // Round-robin pick of a finished line, scanning upward from rr_q.
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (!sel_vld && state_q[(int'(rr_q) + i) % ENTRY_NUM] == ST_DONE) begin
                sel_vld = 1'b1;
                sel     = ENTRY_IDX_W'((int'(rr_q) + i) % ENTRY_NUM);
            end
        end
        load = sel_vld && (!txdat_vld || txdat_rdy);

        if (alloc_vld) begin
            if (state_q[alloc_entry_id] == ST_IDLE) begin
                alloc_ok                = 1'b1;
                state_d[alloc_entry_id] = ST_FILL;
                mask_d[alloc_entry_id]  = '0;
            end else begin
                stray = 1'b1;
            end
        end

        // Beat legality uses the pre-alloc state, so a beat racing its own alloc is stray.
        if (rxdat_vld && rxdat_rdy) begin
            if (state_q[rxdat_entry_id] == ST_FILL && !mask_q[rxdat_entry_id][rxdat_beat_idx]) begin
                beat_wr                                = 1'b1;
                mask_d[rxdat_entry_id][rxdat_beat_idx] = 1'b1;
                if (&mask_d[rxdat_entry_id]) begin
                    state_d[rxdat_entry_id] = ST_DONE;
                end
            end else begin
                stray = 1'b1;
            end
        end

        if (load) begin
            state_d[sel] = ST_OUT;
        end
        // The entry sitting in the output register is always in OUT, never the one being loaded.
        if (hs) begin
            state_d[txdat_entry_id] = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < ENTRY_NUM; e++) begin
                state_q[e] <= ST_IDLE;
                mask_q[e]  <= '0;
            end
            rr_q             <= '0;
            txdat_vld        <= 1'b0;
            txdat_data       <= '0;
            txdat_txnid      <= '0;
            txdat_entry_id   <= '0;
            dealloc_vld      <= 1'b0;
            dealloc_entry_id <= '0;
            err_stray        <= 1'b0;
        end else begin
            for (int e = 0; e < ENTRY_NUM; e++) begin
                state_q[e] <= state_d[e];
                mask_q[e]  <= mask_d[e];
            end
            err_stray   <= err_stray | stray;
            dealloc_vld <= hs;
            if (hs) begin
                dealloc_entry_id <= txdat_entry_id;
            end
            if (load) begin
                txdat_vld      <= 1'b1;
                txdat_data     <= line_q[sel];
                txdat_txnid    <= txnid_q[sel];
                txdat_entry_id <= sel;
                rr_q           <= ENTRY_IDX_W'((int'(sel) + 1) % ENTRY_NUM);
            end else if (hs) begin
                txdat_vld <= 1'b0;
            end
        end
    end

    // Line and txnid storage need no reset: they are only read once the mask is full.
    always_ff @(posedge clk) begin
        if (beat_wr) begin
            line_q[rxdat_entry_id][int'(rxdat_beat_idx)*BEAT_WIDTH +: BEAT_WIDTH] <= rxdat_data;
        end
        if (alloc_ok) begin
            txnid_q[alloc_entry_id] <= alloc_txnid;
        end
    end

endmodule

// File: tb/tb_icache_rxdat_merge.sv
module tb_icache_rxdat_merge;

    localparam int LW = 256;
    localparam int BW = 64;
    localparam int EN = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           alloc_vld = 1'b0;
    logic [2:0]     alloc_entry_id = '0;
    logic [7:0]     alloc_txnid = '0;
    logic           rxdat_vld = 1'b0;
    logic           rxdat_rdy;
    logic [2:0]     rxdat_entry_id = '0;
    logic [1:0]     rxdat_beat_idx = '0;
    logic [BW-1:0]  rxdat_data = '0;
    logic           txdat_vld;
    logic           txdat_rdy = 1'b0;
    logic [LW-1:0]  txdat_data;
    logic [7:0]     txdat_txnid;
    logic [2:0]     txdat_entry_id;
    logic           dealloc_vld;
    logic [2:0]     dealloc_entry_id;
    logic           err_stray;

    icache_rxdat_merge dut (
        .clk(clk), .rst(rst),
        .alloc_vld(alloc_vld), .alloc_entry_id(alloc_entry_id), .alloc_txnid(alloc_txnid),
        .rxdat_vld(rxdat_vld), .rxdat_rdy(rxdat_rdy), .rxdat_entry_id(rxdat_entry_id),
        .rxdat_beat_idx(rxdat_beat_idx), .rxdat_data(rxdat_data),
        .txdat_vld(txdat_vld), .txdat_rdy(txdat_rdy), .txdat_data(txdat_data),
        .txdat_txnid(txdat_txnid), .txdat_entry_id(txdat_entry_id),
        .dealloc_vld(dealloc_vld), .dealloc_entry_id(dealloc_entry_id), .err_stray(err_stray)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            e;
        logic [7:0]    t;
        logic [LW-1:0] d;
    } line_t;

    int total = 0;
    int bad   = 0;

    // Reference model: an entry is busy from a successful alloc until its line is handed off.
    bit            m_busy [EN];
    logic [7:0]    m_tx   [EN];
    logic [LW-1:0] m_line [EN];
    bit [3:0]      m_got  [EN];
    bit            m_err;
    line_t         exp_q[$];
    line_t         got_q[$];
    int            dq[$];

    function automatic int find_exp(int e);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].e == e) return i;
        end
        return -1;
    endfunction

    // Record this cycle's handshake / dealloc, then advance to just after the next edge.
    task automatic tick();
        if (txdat_vld === 1'b1 && txdat_rdy) begin
            got_q.push_back('{int'(txdat_entry_id), txdat_txnid, txdat_data});
            m_busy[txdat_entry_id] = 1'b0;
        end
        if (dealloc_vld === 1'b1) dq.push_back(int'(dealloc_entry_id));
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit av, int ae, logic [7:0] at, bit bv, int be, int bk, logic [BW-1:0] bd);
        alloc_vld      = av;
        alloc_entry_id = 3'(ae);
        alloc_txnid    = at;
        rxdat_vld      = bv;
        rxdat_entry_id = 3'(be);
        rxdat_beat_idx = 2'(bk);
        rxdat_data     = bd;
        if (bv) begin
            if (m_busy[be] && !m_got[be][bk]) begin
                m_got[be][bk] = 1'b1;
                m_line[be][bk*BW +: BW] = bd;
                if (&m_got[be]) exp_q.push_back('{be, m_tx[be], m_line[be]});
            end else begin
                m_err = 1'b1;
            end
        end
        if (av) begin
            if (!m_busy[ae]) begin
                m_busy[ae] = 1'b1;
                m_tx[ae]   = at;
                m_got[ae]  = '0;
            end else begin
                m_err = 1'b1;
            end
        end
        tick();
        alloc_vld = 1'b0;
        rxdat_vld = 1'b0;
    endtask

    task automatic do_alloc(int e, logic [7:0] t);
        drive(1'b1, e, t, 1'b0, 0, 0, '0);
    endtask

    task automatic do_beat(int e, int k, logic [BW-1:0] d);
        drive(1'b0, 0, 8'h00, 1'b1, e, k, d);
    endtask

    function automatic logic [BW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        dq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (txdat_vld !== 1'b0) begin bad++; $display("FAIL reset_txdat_vld got=%b exp=0", txdat_vld); end
        total++; if (txdat_data !== '0 || txdat_txnid !== 8'h00 || txdat_entry_id !== 3'd0) begin
            bad++; $display("FAIL reset_txdat_fields got=%h/%h/%0d exp=0", txdat_data, txdat_txnid, txdat_entry_id); end
        total++; if (dealloc_vld !== 1'b0 || dealloc_entry_id !== 3'd0) begin
            bad++; $display("FAIL reset_dealloc got=%b/%0d exp=0/0", dealloc_vld, dealloc_entry_id); end
        total++; if (err_stray !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_stray); end
        total++; if (rxdat_rdy !== 1'b0) begin bad++; $display("FAIL reset_rxdat_rdy got=%b exp=0", rxdat_rdy); end
        rst = 1'b0;
        #1;
        total++; if (rxdat_rdy !== 1'b1) begin bad++; $display("FAIL run_rxdat_rdy got=%b exp=1", rxdat_rdy); end
        tick();
    endtask

    task automatic test_basic();
        logic [LW-1:0] expd;
        expd = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        clear_q();
        txdat_rdy = 1'b1;
        do_alloc(2, 8'h5A);
        for (int k = 0; k < 4; k++) do_beat(2, k, {8{8'((k + 1) * 17)}});
        // now at T+1 relative to the completing beat
        total++; if (txdat_vld !== 1'b0) begin bad++; $display("FAIL basic_t1_vld got=%b exp=0", txdat_vld); end
        tick();
        total++; if (txdat_vld !== 1'b1) begin bad++; $display("FAIL basic_t2_vld got=%b exp=1", txdat_vld); end
        total++; if (txdat_data !== expd) begin bad++; $display("FAIL basic_data got=%h exp=%h", txdat_data, expd); end
        total++; if (txdat_txnid !== 8'h5A || txdat_entry_id !== 3'd2) begin
            bad++; $display("FAIL basic_id got=%h/%0d exp=5a/2", txdat_txnid, txdat_entry_id); end
        tick();
        total++; if (dealloc_vld !== 1'b1 || dealloc_entry_id !== 3'd2) begin
            bad++; $display("FAIL basic_dealloc got=%b/%0d exp=1/2", dealloc_vld, dealloc_entry_id); end
        total++; if (txdat_vld !== 1'b0) begin bad++; $display("FAIL basic_t3_vld got=%b exp=0", txdat_vld); end
        tick();
        total++; if (dealloc_vld !== 1'b0) begin bad++; $display("FAIL basic_dealloc_pulse got=%b exp=0", dealloc_vld); end
    endtask

    task automatic test_interleave();
        int o1[4] = '{3, 1, 0, 2};
        clear_q();
        txdat_rdy = 1'b1;
        do_alloc(1, 8'h31);
        do_alloc(4, 8'h34);
        for (int i = 0; i < 4; i++) begin
            do_beat(1, o1[i], rnd64());
            do_beat(4, i, rnd64());
        end
        repeat (4) tick();
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL ilv_count got=%0d exp=2", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            int j;
            j = find_exp(got_q[i].e);
            total++;
            if (j < 0) begin
                bad++; $display("FAIL ilv_line unexpected entry=%0d", got_q[i].e);
            end else begin
                if (got_q[i].d !== exp_q[j].d || got_q[i].t !== exp_q[j].t) begin
                    bad++; $display("FAIL ilv_line e=%0d got=%h/%h exp=%h/%h", got_q[i].e, got_q[i].t, got_q[i].d, exp_q[j].t, exp_q[j].d);
                end
                exp_q.delete(j);
            end
        end
        total++; if (err_stray !== 1'b0) begin bad++; $display("FAIL ilv_err got=%b exp=0", err_stray); end
    endtask

    task automatic test_rr_hold();
        int ord[3] = '{0, 3, 5};
        clear_q();
        txdat_rdy = 1'b0;
        do_alloc(0, 8'hA0);
        do_alloc(3, 8'hA3);
        do_alloc(5, 8'hA5);
        for (int k = 0; k < 3; k++) begin
            do_beat(3, k, rnd64());
            do_beat(5, k, rnd64());
        end
        for (int k = 0; k < 4; k++) do_beat(0, k, rnd64());
        do_beat(3, 3, rnd64());
        do_beat(5, 3, rnd64());
        for (int c = 0; c < 5; c++) begin
            total++;
            if (txdat_vld !== 1'b1 || txdat_entry_id !== 3'd0 || txdat_data !== m_line[0] || txdat_txnid !== 8'hA0) begin
                bad++; $display("FAIL rr_hold c=%0d got=%b/%0d/%h exp=1/0/%h", c, txdat_vld, txdat_entry_id, txdat_data, m_line[0]);
            end
            tick();
        end
        txdat_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (txdat_vld !== 1'b1 || txdat_entry_id !== 3'(ord[i]) || txdat_txnid !== m_tx[ord[i]] || txdat_data !== m_line[ord[i]]) begin
                bad++; $display("FAIL rr_order i=%0d got=%b/%0d/%h exp=1/%0d/%h", i, txdat_vld, txdat_entry_id, txdat_txnid, ord[i], m_tx[ord[i]]);
            end
            tick();
        end
        total++; if (txdat_vld !== 1'b0) begin bad++; $display("FAIL rr_drained got=%b exp=0", txdat_vld); end
        tick();
    endtask

    task automatic test_realloc();
        clear_q();
        txdat_rdy = 1'b1;
        do_alloc(0, 8'h70);
        for (int k = 0; k < 4; k++) do_beat(0, k, rnd64());
        tick();
        total++; if (txdat_vld !== 1'b1 || txdat_entry_id !== 3'd0) begin
            bad++; $display("FAIL realloc_first got=%b/%0d exp=1/0", txdat_vld, txdat_entry_id); end
        tick();
        total++; if (dealloc_vld !== 1'b1 || dealloc_entry_id !== 3'd0) begin
            bad++; $display("FAIL realloc_dealloc got=%b/%0d exp=1/0", dealloc_vld, dealloc_entry_id); end
        do_alloc(0, 8'h77);
        for (int k = 0; k < 4; k++) do_beat(0, k, rnd64());
        tick();
        total++; if (txdat_vld !== 1'b1 || txdat_txnid !== 8'h77 || txdat_data !== m_line[0]) begin
            bad++; $display("FAIL realloc_second got=%b/%h exp=1/77", txdat_vld, txdat_txnid); end
        total++; if (err_stray !== 1'b0) begin bad++; $display("FAIL realloc_err got=%b exp=0", err_stray); end
        repeat (2) tick();
    endtask

    task automatic test_stray();
        logic [BW-1:0] b1;
        clear_q();
        txdat_rdy = 1'b1;
        b1 = rnd64();
        do_alloc(2, 8'h22);
        do_beat(2, 1, b1);
        total++; if (err_stray !== 1'b0) begin bad++; $display("FAIL stray_pre got=%b exp=0", err_stray); end
        do_beat(6, 0, rnd64());
        total++; if (err_stray !== 1'b1) begin bad++; $display("FAIL stray_idle got=%b exp=1", err_stray); end
        do_beat(2, 1, ~b1);
        do_alloc(2, 8'hEE);
        do_beat(2, 0, rnd64());
        do_beat(2, 2, rnd64());
        do_beat(2, 3, rnd64());
        tick();
        total++;
        if (txdat_vld !== 1'b1 || txdat_txnid !== 8'h22 || txdat_data[BW +: BW] !== b1 || txdat_data !== m_line[2]) begin
            bad++; $display("FAIL stray_line got=%b/%h/%h exp=1/22/%h", txdat_vld, txdat_txnid, txdat_data, m_line[2]);
        end
        total++; if (err_stray !== m_err) begin bad++; $display("FAIL stray_sticky got=%b exp=%b", err_stray, m_err); end
        repeat (2) tick();
    endtask

    task automatic test_random();
        int lines;
        clear_q();
        for (int c = 0; c < 1500; c++) begin
            txdat_rdy = ($urandom_range(3) != 0);
            drive($urandom_range(5) == 0, $urandom_range(7), 8'($urandom),
                  $urandom_range(3) != 0, $urandom_range(7), $urandom_range(3), rnd64());
        end
        txdat_rdy = 1'b1;
        repeat (20) tick();
        lines = got_q.size();
        total++; if (lines < 5) begin bad++; $display("FAIL rand_activity got=%0d lines exp>=5", lines); end
        for (int i = 0; i < got_q.size(); i++) begin
            int j;
            j = find_exp(got_q[i].e);
            total++;
            if (j < 0) begin
                bad++; $display("FAIL rand_line unexpected entry=%0d", got_q[i].e);
            end else begin
                if (got_q[i].d !== exp_q[j].d || got_q[i].t !== exp_q[j].t) begin
                    bad++; $display("FAIL rand_line e=%0d got=%h exp=%h", got_q[i].e, got_q[i].t, exp_q[j].t);
                end
                exp_q.delete(j);
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_unissued got=%0d exp=0", exp_q.size()); end
        total++;
        if (dq.size() != got_q.size()) begin
            bad++; $display("FAIL rand_dealloc_count got=%0d exp=%0d", dq.size(), got_q.size());
        end else begin
            for (int i = 0; i < dq.size(); i++) begin
                if (dq[i] != got_q[i].e) begin
                    bad++; $display("FAIL rand_dealloc_id i=%0d got=%0d exp=%0d", i, dq[i], got_q[i].e);
                    break;
                end
            end
        end
        total++; if (err_stray !== m_err) begin bad++; $display("FAIL rand_err got=%b exp=%b", err_stray, m_err); end
    endtask

    task automatic test_reset_mid();
        clear_q();
        txdat_rdy = 1'b0;
        do_alloc(3, 8'hC3);
        for (int k = 0; k < 4; k++) do_beat(3, k, rnd64());
        do_alloc(1, 8'hC1);
        do_beat(1, 0, rnd64());
        do_beat(1, 1, rnd64());
        total++; if (txdat_vld !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b exp=1", txdat_vld); end
        #2 rst = 1'b1;
        #1;
        total++;
        if (txdat_vld !== 1'b0 || txdat_data !== '0 || txdat_txnid !== 8'h00 || txdat_entry_id !== 3'd0 ||
            dealloc_vld !== 1'b0 || err_stray !== 1'b0 || rxdat_rdy !== 1'b0) begin
            bad++; $display("FAIL rstmid_outputs got=%b/%h/%0d/%b/%b/%b exp=all0", txdat_vld, txdat_txnid, txdat_entry_id, dealloc_vld, err_stray, rxdat_rdy);
        end
        for (int e = 0; e < EN; e++) begin
            m_busy[e] = 1'b0;
            m_got[e]  = '0;
        end
        m_err = 1'b0;
        clear_q();
        @(posedge clk);
        #1;
        rst = 1'b0;
        txdat_rdy = 1'b1;
        repeat (3) tick();
        total++; if (dq.size() != 0 || got_q.size() != 0) begin
            bad++; $display("FAIL rstmid_no_output got=%0d/%0d exp=0/0", dq.size(), got_q.size()); end
        do_alloc(1, 8'hD1);
        for (int k = 0; k < 4; k++) do_beat(1, k, rnd64());
        repeat (3) tick();
        total++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            bad++; $display("FAIL rstmid_refill_count got=%0d exp=1", got_q.size());
        end else if (got_q[0].e != 1 || got_q[0].t !== 8'hD1 || got_q[0].d !== exp_q[0].d) begin
            bad++; $display("FAIL rstmid_refill e=%0d t=%h exp=1/d1", got_q[0].e, got_q[0].t);
        end
        total++; if (err_stray !== 1'b0) begin bad++; $display("FAIL rstmid_err got=%b exp=0", err_stray); end
    endtask

    initial begin
        for (int e = 0; e < EN; e++) begin
            m_busy[e] = 1'b0;
            m_got[e]  = '0;
            m_tx[e]   = '0;
            m_line[e] = '0;
        end
        m_err = 1'b0;
        test_reset();
        test_basic();
        test_interleave();
        test_rr_hold();
        test_realloc();
        test_stray();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
